// File: rtl/pulse_train_tx_pkg.sv
// Shared definitions for the pulse-train transmitter: FSM encodings and the
// microsecond-to-cycle helper also used by the clock-divider blocks.
package pulse_train_tx_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  function automatic int cycles_from_us(input int clock_speed_mhz, input int us);
    return clock_speed_mhz * us;
  endfunction

endpackage

// File: rtl/pulse_train_tx_interval_timer.sv
// Loadable down-counter that stops at zero; EXPIRED is high while the count is zero.
module interval_timer #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         LOAD,
  input  logic [W-1:0] LOAD_VALUE,
  output logic         EXPIRED
);

  logic [W-1:0] count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (LOAD) begin
      count <= LOAD_VALUE;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign EXPIRED = (count == '0);

endmodule

// File: rtl/pulse_train_tx.sv
// Emits DATA timed pulses on PULSE_OUT followed by a fixed low gap, with a
// start/ready/done handshake. All outputs come straight from flops.
module pulse_train_tx
  import pulse_train_tx_pkg::*;
#(
  parameter int CLOCK_SPEED_MHZ = 12,
  parameter int ON_US           = 200000,
  parameter int OFF_US          = 200000,
  parameter int GAP_US          = 1000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] DATA,
  input  logic       START,
  output logic       READY,
  output logic       BUSY,
  output logic       DONE,
  output logic       PULSE_OUT,
  output logic       PULSE_OUT_N
);

  localparam int ON_CYCLES  = cycles_from_us(CLOCK_SPEED_MHZ, ON_US);
  localparam int OFF_CYCLES = cycles_from_us(CLOCK_SPEED_MHZ, OFF_US);
  localparam int GAP_CYCLES = cycles_from_us(CLOCK_SPEED_MHZ, GAP_US);
  localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES)
                              ? ((ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES)
                              : ((OFF_CYCLES > GAP_CYCLES) ? OFF_CYCLES : GAP_CYCLES);
  localparam int TW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  logic [1:0]    state, state_nx;
  logic [7:0]    remaining, remaining_nx;
  logic [7:0]    remaining_dec;
  logic          pulse_nx, done_nx;
  logic          timer_load;
  logic [TW-1:0] timer_load_value;
  logic          timer_expired;

  interval_timer #(.W(TW)) u_timer (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .LOAD       (timer_load),
    .LOAD_VALUE (timer_load_value),
    .EXPIRED    (timer_expired)
  );

  assign remaining_dec = remaining - 8'd1;

  always_comb begin
    state_nx         = state;
    remaining_nx     = remaining;
    pulse_nx         = PULSE_OUT;
    done_nx          = 1'b0;
    timer_load       = 1'b0;
    timer_load_value = '0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          timer_load = 1'b1;
          if (DATA != 8'd0) begin
            remaining_nx     = DATA;
            timer_load_value = ON_LOAD;
            pulse_nx         = 1'b1;
            state_nx         = ST_ON;
          end else begin
            timer_load_value = GAP_LOAD;
            state_nx         = ST_GAP;
          end
        end
      end
      ST_ON: begin
        if (timer_expired) begin
          remaining_nx = remaining_dec;
          pulse_nx     = 1'b0;
          timer_load   = 1'b1;
          // The last pulse is followed by the gap instead of an inter-pulse low.
          if (remaining_dec == 8'd0) begin
            timer_load_value = GAP_LOAD;
            state_nx         = ST_GAP;
          end else begin
            timer_load_value = OFF_LOAD;
            state_nx         = ST_OFF;
          end
        end
      end
      ST_OFF: begin
        if (timer_expired) begin
          timer_load       = 1'b1;
          timer_load_value = ON_LOAD;
          pulse_nx         = 1'b1;
          state_nx         = ST_ON;
        end
      end
      default: begin
        if (timer_expired) begin
          done_nx  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      remaining   <= 8'd0;
      READY       <= 1'b1;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      PULSE_OUT   <= 1'b0;
      PULSE_OUT_N <= 1'b1;
    end else begin
      state       <= state_nx;
      remaining   <= remaining_nx;
      READY       <= (state_nx == ST_IDLE);
      BUSY        <= (state_nx != ST_IDLE);
      DONE        <= done_nx;
      PULSE_OUT   <= pulse_nx;
      PULSE_OUT_N <= ~pulse_nx;
    end
  end

  a_cycles_nonzero: assert property (@(posedge CLK)
    (ON_CYCLES >= 1) && (OFF_CYCLES >= 1) && (GAP_CYCLES >= 1))
    else $error("pulse_train_tx: ON/OFF/GAP cycle counts must each be at least 1");

endmodule

// File: tb/tb_pulse_train_tx.sv
// Directed bench for pulse_train_tx with short timing (1 MHz, 3/2/5 us).
module tb_pulse_train_tx;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       START = 1'b0;
  logic [7:0] DATA = 8'd0;
  logic       READY, BUSY, DONE, PULSE_OUT, PULSE_OUT_N;

  int n_cmp = 0;
  int n_err = 0;

  pulse_train_tx #(
    .CLOCK_SPEED_MHZ (1),
    .ON_US           (3),
    .OFF_US          (2),
    .GAP_US          (5)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .DATA        (DATA),
    .START       (START),
    .READY       (READY),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .PULSE_OUT   (PULSE_OUT),
    .PULSE_OUT_N (PULSE_OUT_N)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts one frame and samples on falling edges until BUSY drops.
  // A START/DATA poke is applied once busy_cyc reaches poke_at (0 disables).
  task automatic run_frame(input logic [7:0] d, input int poke_at, input logic [7:0] poke_d,
                           output int busy_cyc, output int rises, output logic [31:0] pat);
    int   guard;
    int   inv_err;
    int   early_done;
    logic prev;
    busy_cyc = 0; rises = 0; pat = '0; prev = 1'b0; guard = 0; inv_err = 0; early_done = 0;
    @(negedge CLK);
    DATA  = d;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    while (BUSY && guard < 2000) begin
      pat = {pat[30:0], PULSE_OUT};
      if (PULSE_OUT && !prev) rises++;
      if (PULSE_OUT_N !== ~PULSE_OUT) inv_err++;
      if (DONE) early_done++;
      prev = PULSE_OUT;
      busy_cyc++;
      START = (busy_cyc == poke_at);
      if (busy_cyc == poke_at) DATA = poke_d;
      @(negedge CLK);
      guard++;
    end
    START = 1'b0;
    check_eq("frame_end_busy", BUSY, 0);
    check_eq("pulse_n_inverse", inv_err, 0);
    check_eq("done_while_busy", early_done, 0);
    check_eq("done_strobe", DONE, 1);
    check_eq("ready_with_done", READY, 1);
    @(negedge CLK);
    check_eq("done_one_cycle", DONE, 0);
  endtask

  initial begin
    int          busy_cyc;
    int          rises;
    logic [31:0] pat;
    int          guard;

    // Reset then idle
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    check_eq("rst_pulse", PULSE_OUT, 0);
    RST_N = 1'b1;
    @(negedge CLK);
    check_eq("idle_ready", READY, 1);
    check_eq("idle_busy", BUSY, 0);
    check_eq("idle_pulse", PULSE_OUT, 0);
    check_eq("idle_pulse_n", PULSE_OUT_N, 1);
    check_eq("idle_done", DONE, 0);

    // DATA=3: H3 L2 H3 L2 H3 L5
    run_frame(8'd3, 0, 8'd0, busy_cyc, rises, pat);
    check_eq("n3_busy", busy_cyc, 18);
    check_eq("n3_rises", rises, 3);
    check_eq("n3_pattern", int'(pat[17:0]), int'(18'b111001110011100000));

    // DATA=0: gap only
    run_frame(8'd0, 0, 8'd0, busy_cyc, rises, pat);
    check_eq("n0_busy", busy_cyc, 5);
    check_eq("n0_rises", rises, 0);

    // DATA=2 with DATA=7/START poked mid-frame: 2*3+2+5 = 13
    run_frame(8'd2, 4, 8'd7, busy_cyc, rises, pat);
    check_eq("n2_busy", busy_cyc, 13);
    check_eq("n2_rises", rises, 2);
    check_eq("n2_pattern", int'(pat[12:0]), int'(13'b1110011100000));

    // DATA=255: no wrap
    run_frame(8'd255, 0, 8'd0, busy_cyc, rises, pat);
    check_eq("n255_busy", busy_cyc, 1278);
    check_eq("n255_rises", rises, 255);

    // START held high re-triggers on the DONE cycle
    @(negedge CLK);
    DATA  = 8'd1;
    START = 1'b1;
    guard = 0;
    do begin
      @(negedge CLK);
      guard++;
    end while (!DONE && guard < 100);
    check_eq("retrig_done1", DONE, 1);
    check_eq("retrig_idle_busy", BUSY, 0);
    @(negedge CLK);
    check_eq("retrig_busy", BUSY, 1);
    check_eq("retrig_pulse", PULSE_OUT, 1);
    START = 1'b0;
    guard = 0;
    while (BUSY && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    check_eq("retrig_done2", DONE, 1);
    check_eq("retrig_len", guard, 8);

    // DATA=5, reset mid second pulse
    @(negedge CLK);
    DATA  = 8'd5;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (7) @(negedge CLK);
    check_eq("mid_pulse_high", PULSE_OUT, 1);
    #2 RST_N = 1'b0;
    #1;
    check_eq("async_pulse", PULSE_OUT, 0);
    check_eq("async_pulse_n", PULSE_OUT_N, 1);
    check_eq("async_busy", BUSY, 0);
    check_eq("async_ready", READY, 1);
    repeat (2) @(negedge CLK);
    check_eq("rst_no_done", DONE, 0);
    RST_N = 1'b1;
    @(negedge CLK);
    check_eq("post_rst_ready", READY, 1);
    check_eq("post_rst_done", DONE, 0);
    run_frame(8'd1, 0, 8'd0, busy_cyc, rises, pat);
    check_eq("n1_busy", busy_cyc, 8);
    check_eq("n1_rises", rises, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
